// File: rtl/dmem_lsu.sv
// Data-memory load/store responder: decodes byte/half/word requests into RAM word accesses, splitting misaligned ones.
// Latency 1 cycle aligned, 2 split; req_ready drops only during the split second access, response has no backpressure.
module dmem_lsu #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DWIDTH-1:0] resp_rdata,
   output logic              ram_en,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [3:0]        ram_wbe,
   output logic [DWIDTH-1:0] ram_d,
   input  logic [DWIDTH-1:0] ram_q
);

   typedef enum logic {S_IDLE, S_SPLIT} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_resp_vld;
   logic                r_we;
   logic [1:0]          r_size;
   logic                r_uns;
   logic [1:0]          r_off;
   logic                r_split;
   logic [DWIDTH-1:0]   r_wdata;
   logic [AWIDTH-1:0]   r_wa1;
   logic [DWIDTH-1:0]   r_lo;

   logic [1:0]          w_off;
   logic [AWIDTH-1:0]   w_wa;
   logic [3:0]          w_base;
   logic [7:0]          w_mask8;
   logic [3:0]          w_rbase;
   logic [7:0]          w_rmask8;
   logic                w_split;
   logic                w_accept;
   logic [63:0]         w_pair;
   logic [DWIDTH-1:0]   w_raw;
   logic [DWIDTH-1:0]   w_ext;
   logic                w_unused;

   assign w_off    = req_addr[1:0];
   assign w_wa     = req_addr[AWIDTH+1:2];
   assign w_unused = &{1'b0, req_addr[31:AWIDTH+2]};

   always_comb begin
      w_base = 4'b1111;
      if (req_size == 2'b00)      w_base = 4'b0001;
      else if (req_size == 2'b01) w_base = 4'b0011;
      w_rbase = 4'b1111;
      if (r_size == 2'b00)        w_rbase = 4'b0001;
      else if (r_size == 2'b01)   w_rbase = 4'b0011;
   end

   assign w_mask8  = {4'b0000, w_base} << w_off;
   assign w_rmask8 = {4'b0000, w_rbase} << r_off;
   assign w_split  = |w_mask8[7:4];

   assign req_ready = (r_state == S_IDLE);
   // Reset gates acceptance so nothing reaches the RAM during a reset cycle.
   assign w_accept  = req_valid && rst_n && (r_state == S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      ram_en      = 1'b0;
      ram_addr    = '0;
      ram_wbe     = 4'b0000;
      ram_d       = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               ram_en   = 1'b1;
               ram_addr = w_wa;
               if (req_we) begin
                  ram_wbe = w_mask8[3:0];
                  ram_d   = req_wdata << {w_off, 3'b000};
               end
               if (w_split) w_state_nxt = S_SPLIT;
            end
         end
         S_SPLIT: begin
            w_state_nxt = S_IDLE;
            if (rst_n) begin
               ram_en   = 1'b1;
               ram_addr = r_wa1;
               if (r_we) begin
                  ram_wbe = w_rmask8[7:4];
                  ram_d   = r_wdata >> (6'd32 - {1'b0, r_off, 3'b000});
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_resp_vld <= 1'b0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_uns      <= 1'b0;
         r_off      <= 2'b00;
         r_split    <= 1'b0;
         r_wdata    <= '0;
         r_wa1      <= '0;
         r_lo       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_resp_vld <= (w_accept && !w_split) || (r_state == S_SPLIT);
         if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_off   <= w_off;
            r_split <= w_split;
            r_wdata <= req_wdata;
            r_wa1   <= w_wa + 1'b1;
         end
         // The first word of a split load arrives while the second is being read.
         if (r_state == S_SPLIT && !r_we) r_lo <= ram_q;
      end
   end

   assign w_pair = {ram_q, r_lo} >> {r_off, 3'b000};
   assign w_raw  = r_split ? w_pair[31:0] : (ram_q >> {r_off, 3'b000});

   always_comb begin
      w_ext = w_raw;
      if (r_size == 2'b00)      w_ext = {{24{w_raw[7]  & ~r_uns}}, w_raw[7:0]};
      else if (r_size == 2'b01) w_ext = {{16{w_raw[15] & ~r_uns}}, w_raw[15:0]};
   end

   assign resp_valid = r_resp_vld;
   assign resp_rdata = (r_resp_vld && !r_we) ? w_ext : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural write-byte-enable RAM plus a response scoreboard fed at request time.
// Each scenario task drives requests and checks RAM-side signals itself; the monitor checks responses in order.
module tb_dmem_lsu;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_wbe;
   logic [31:0]   ram_d;
   logic [31:0]   ram_q;

   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_dat = '0;
   logic [31:0]   mem [0:(1<<AW)-1];

   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   exp_q [$];

   always #5 clk = ~clk;

   dmem_lsu #(.DWIDTH(32), .AWIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .ram_en(ram_en), .ram_addr(ram_addr),
      .ram_wbe(ram_wbe), .ram_d(ram_d), .ram_q(ram_q)
   );

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_dat;
      end else if (ram_en === 1'b1) begin
         ram_q <= mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_wbe[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
   endtask

   task automatic monitor_resp();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL resp_unexpected: resp_valid=1 rdata=%h, required no response", resp_rdata);
            end else begin
               e = exp_q.pop_front();
               if (resp_rdata !== e) begin
                  n_errors++;
                  $display("FAIL resp_rdata: got %h required %h", resp_rdata, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (ram_en !== 1'b0 || ram_wbe !== 4'b0000 || resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: en=%b wbe=%b rv=%b required 0 0000 0", ram_en, ram_wbe, resp_valid);
         end
         @(posedge clk);
      end
      #1 rst_n = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: ready=%b rv=%b required 1 0", req_ready, resp_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_byte();
      drive(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AB);
      exp_q.push_back(32'h0);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 14'd1 || ram_wbe !== 4'b0100 || ram_d !== 32'h00AB_0000) begin
         n_errors++;
         $display("FAIL store_byte: rdy=%b en=%b addr=%h wbe=%b d=%h required 1 1 0001 0100 00ab0000",
                  req_ready, ram_en, ram_addr, ram_wbe, ram_d);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || ram_en !== 1'b0) begin
         n_errors++;
         $display("FAIL store_byte_resp: rv=%b en=%b required 1 0", resp_valid, ram_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
      logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad  [4] = '{32'h7, 32'h7, 32'h4, 32'h4};
      logic [31:0] ex  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h80FF_7F01};
      preload(14'd1, 32'h80FF_7F01);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, sz[i], uns[i], ad[i], 32'hDEAD_BEEF);
         exp_q.push_back(ex[i]);
         @(negedge clk);
         n_checks++;
         if (req_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 14'd1 || ram_wbe !== 4'b0000 || ram_d !== 32'h0) begin
            n_errors++;
            $display("FAIL load_issue%0d: rdy=%b en=%b addr=%h wbe=%b d=%h required 1 1 0001 0000 0", i,
                     req_ready, ram_en, ram_addr, ram_wbe, ram_d);
         end
         if (i > 0) begin
            n_checks++;
            if (resp_valid !== 1'b1) begin
               n_errors++;
               $display("FAIL b2b_rate%0d: resp_valid=%b required 1", i, resp_valid);
            end
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL b2b_idle: rv=%b rdata=%h required 0 0", resp_valid, resp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_split_store();
      drive(1'b1, 2'b10, 1'b0, 32'h0000_000B, 32'h1122_3344);
      exp_q.push_back(32'h0);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || ram_addr !== 14'd2 || ram_wbe !== 4'b1000 || ram_d !== 32'h4400_0000) begin
         n_errors++;
         $display("FAIL split_st_c0: rdy=%b addr=%h wbe=%b d=%h required 1 0002 1000 44000000",
                  req_ready, ram_addr, ram_wbe, ram_d);
      end
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'h0000_000B, 32'h0);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 14'd3 || ram_wbe !== 4'b0111 ||
          ram_d !== 32'h0011_2233 || resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL split_st_c1: rdy=%b en=%b addr=%h wbe=%b d=%h rv=%b required 0 1 0003 0111 00112233 0",
                  req_ready, ram_en, ram_addr, ram_wbe, ram_d, resp_valid);
      end
      @(posedge clk); #1;
      exp_q.push_back(32'h1122_3344);
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 14'd2 || ram_wbe !== 4'b0000) begin
         n_errors++;
         $display("FAIL split_st_c2: rv=%b rdy=%b en=%b addr=%h wbe=%b required 1 1 1 0002 0000",
                  resp_valid, req_ready, ram_en, ram_addr, ram_wbe);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b0 || ram_addr !== 14'd3 || ram_wbe !== 4'b0000) begin
         n_errors++;
         $display("FAIL split_ld_c1: rdy=%b addr=%h wbe=%b required 0 0003 0000", req_ready, ram_addr, ram_wbe);
      end
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_split_load_half();
      preload(14'd2, 32'hAA00_0000);
      preload(14'd3, 32'h0000_00F0);
      drive(1'b0, 2'b01, 1'b0, 32'h0000_000B, 32'h0);
      exp_q.push_back(32'hFFFF_F0AA);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL split_lh_early: resp_valid=%b required 0", resp_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_F0AA) begin
         n_errors++;
         $display("FAIL split_lh_data: rv=%b rdata=%h required 1 fffff0aa", resp_valid, resp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      preload(14'h3FFF, 32'h5566_7788);
      preload(14'h0000, 32'h1122_3344);
      drive(1'b0, 2'b10, 1'b0, 32'h1234_FFFE, 32'h0);
      exp_q.push_back(32'h3344_5566);
      @(negedge clk);
      n_checks++;
      if (ram_addr !== 14'h3FFF || ram_en !== 1'b1) begin
         n_errors++;
         $display("FAIL wrap_c0: addr=%h en=%b required 3fff 1", ram_addr, ram_en);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ram_addr !== 14'h0000 || ram_en !== 1'b1 || req_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_c1: addr=%h en=%b rdy=%b required 0000 1 0", ram_addr, ram_en, req_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_split();
      preload(14'd2, 32'h0);
      preload(14'd3, 32'h0);
      drive(1'b1, 2'b10, 1'b0, 32'h0000_000B, 32'hDEAD_BEEF);
      @(negedge clk);
      n_checks++;
      if (ram_wbe !== 4'b1000 || ram_d !== 32'hEF00_0000) begin
         n_errors++;
         $display("FAIL rst_split_c0: wbe=%b d=%h required 1000 ef000000", ram_wbe, ram_d);
      end
      @(posedge clk); #1 rst_n = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ram_en !== 1'b0 || ram_wbe !== 4'b0000) begin
         n_errors++;
         $display("FAIL rst_split_ram: en=%b wbe=%b required 0 0000", ram_en, ram_wbe);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_split_after: rv=%b rdy=%b required 0 1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
      exp_q.push_back(32'hEF00_0000);
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
      exp_q.push_back(32'h0000_0000);
      @(posedge clk); #1 req_valid = 1'b0;
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rst_n = 1'b0;
      fork
         monitor_resp();
      join_none
      test_reset();
      test_store_byte();
      test_back_to_back();
      test_split_store();
      test_split_load_half();
      test_wrap();
      test_reset_in_split();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL resp_missing: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
